// File: rtl/vai_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vai_pkg
// Description : Shared opcodes, FSM state type and header field offsets for
//               the VAI register file.
// Revision    : 1.0 - initial release
// ============================================================================
package vai_pkg;

    localparam int OPC_W    = 4;
    localparam int OPC_LSB  = 0;
    localparam int ADDR_LSB = 4;

    localparam logic [OPC_W-1:0] OPC_READ  = 4'd0;
    localparam logic [OPC_W-1:0] OPC_WRITE = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_GET_HEADER   = 3'd1,
        ST_GET_DATA     = 3'd2,
        ST_DRAIN        = 3'd3,
        ST_EXECUTE      = 3'd4,
        ST_SEND_HEADER  = 3'd5,
        ST_SEND_PAYLOAD = 3'd6
    } state_t;

    // The error flag always occupies the top bit of a beat.
    function automatic int errBit(input int dataW);
        return dataW - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vai_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : vai_regfile_if
// Description : Framed VAI request/response stream pair (Valid/Accept/Start/Stop).
// Revision    : 1.0 - initial release
// ============================================================================
interface vai_regfile_if #(
    parameter int DATA_W = 16
) ();

    logic [DATA_W-1:0] Din;
    logic              DinValid;
    logic              DinStart;
    logic              DinStop;
    logic              DinAccept;
    logic [DATA_W-1:0] Dout;
    logic              DoutValid;
    logic              DoutStart;
    logic              DoutStop;
    logic              DoutAccept;

    modport master (
        output Din, DinValid, DinStart, DinStop,
        input  DinAccept,
        input  Dout, DoutValid, DoutStart, DoutStop,
        output DoutAccept
    );

    modport slave (
        input  Din, DinValid, DinStart, DinStop,
        output DinAccept,
        output Dout, DoutValid, DoutStart, DoutStop,
        input  DoutAccept
    );

endinterface
`default_nettype wire

// File: rtl/vai_regfile_bank.sv
`default_nettype none
// ============================================================================
// Module      : vai_regfile_bank
// Description : Register storage with address range check, read-only masking
//               and parallel export of all register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module vai_regfile_bank #(
    parameter int                  DATA_W   = 16,
    parameter int                  ADDR_W   = 4,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         Clk_i,
    input  logic                         Reset_i,
    input  logic [ADDR_W-1:0]            Addr_i,
    input  logic                         WrEn_i,
    input  logic [DATA_W-1:0]            WrData_i,
    output logic [DATA_W-1:0]            RdData_o,
    output logic                         AddrOk_o,
    output logic                         ReadOnly_o,
    output logic [NUM_REGS*DATA_W-1:0]   Regs_o
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // An address that matches no implemented register is out of range.
    always_comb begin
        RdData_o   = '0;
        AddrOk_o   = 1'b0;
        ReadOnly_o = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Addr_i == ADDR_W'(i)) begin
                RdData_o   = r_regs[i];
                AddrOk_o   = 1'b1;
                ReadOnly_o = RO_MASK[i];
            end
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WrEn_i && AddrOk_o && !ReadOnly_o) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (Addr_i == ADDR_W'(i)) begin
                    r_regs[i] <= WrData_i;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
        assign Regs_o[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

endmodule
`default_nettype wire

// File: rtl/vai_regfile.sv
`default_nettype none
// ============================================================================
// Module      : vai_regfile
// Description : Bank of NUM_REGS registers read/written through framed VAI
//               request frames; every request yields a header+payload response.
// Revision    : 1.0 - initial release
// ============================================================================
module vai_regfile
    import vai_pkg::*;
#(
    parameter int                  DATA_W   = 16,
    parameter int                  ADDR_W   = 4,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       Clk_i,
    input  logic                       Reset_i,
    vai_regfile_if.slave               vai,
    output logic [NUM_REGS*DATA_W-1:0] Regs_o
);

    localparam int ERR_BIT = errBit(DATA_W);

    state_t            r_state;
    logic              r_dinAccept;
    logic              r_err;
    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_dout;
    logic              r_doutValid;
    logic              r_doutStart;
    logic              r_doutStop;

    logic [OPC_W-1:0]  w_reqOpc;
    logic [OPC_W-1:0]  w_opc;
    logic              w_goodRead;
    logic              w_goodWrite;
    logic              w_isWrite;
    logic              w_inXfer;
    logic              w_outXfer;
    logic              w_addrOk;
    logic              w_readOnly;
    logic              w_execErr;
    logic              w_wrEn;
    logic [DATA_W-1:0] w_rdData;
    logic [DATA_W-1:0] w_respHdr;

    always_comb begin
        w_reqOpc    = vai.Din[OPC_LSB +: OPC_W];
        w_goodRead  = (w_reqOpc == OPC_READ)  &&  vai.DinStop;
        w_goodWrite = (w_reqOpc == OPC_WRITE) && !vai.DinStop;
        w_opc       = r_hdr[OPC_LSB +: OPC_W];
        w_isWrite   = (w_opc == OPC_WRITE);
        w_inXfer    = vai.DinValid && r_dinAccept;
        w_outXfer   = r_doutValid && vai.DoutAccept;
        w_execErr   = r_err || !w_addrOk || (w_isWrite && w_readOnly);
        w_wrEn      = (r_state == ST_EXECUTE) && w_isWrite && !r_err;
        w_respHdr   = r_hdr;
        w_respHdr[ERR_BIT] = w_execErr;
    end

    vai_regfile_bank #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_bank (
        .Clk_i      (Clk_i),
        .Reset_i    (Reset_i),
        .Addr_i     (r_hdr[ADDR_LSB +: ADDR_W]),
        .WrEn_i     (w_wrEn),
        .WrData_i   (r_data),
        .RdData_o   (w_rdData),
        .AddrOk_o   (w_addrOk),
        .ReadOnly_o (w_readOnly),
        .Regs_o     (Regs_o)
    );

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_state     <= ST_IDLE;
            r_dinAccept <= 1'b0;
            r_err       <= 1'b0;
            r_hdr       <= '0;
            r_data      <= '0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_doutStart <= 1'b0;
            r_doutStop  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_GET_HEADER;
                    r_dinAccept <= 1'b1;
                end
                // Beats without Start are silently dropped here.
                ST_GET_HEADER: begin
                    if (w_inXfer && vai.DinStart) begin
                        r_hdr <= vai.Din;
                        r_err <= !(w_goodRead || w_goodWrite);
                        if (w_goodWrite) begin
                            r_state <= ST_GET_DATA;
                        end else if (vai.DinStop) begin
                            r_state     <= ST_EXECUTE;
                            r_dinAccept <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (w_inXfer) begin
                        r_data <= vai.Din;
                        if (vai.DinStart) begin
                            r_err <= 1'b1;
                        end
                        if (vai.DinStop) begin
                            r_state     <= ST_EXECUTE;
                            r_dinAccept <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_inXfer && vai.DinStop) begin
                        r_state     <= ST_EXECUTE;
                        r_dinAccept <= 1'b0;
                    end
                end
                // r_data is reused to hold the response payload.
                ST_EXECUTE: begin
                    r_dout      <= w_respHdr;
                    r_doutValid <= 1'b1;
                    r_doutStart <= 1'b1;
                    r_data      <= w_execErr ? '0 : (w_isWrite ? r_data : w_rdData);
                    r_state     <= ST_SEND_HEADER;
                end
                ST_SEND_HEADER: begin
                    if (w_outXfer) begin
                        r_dout      <= r_data;
                        r_doutStart <= 1'b0;
                        r_doutStop  <= 1'b1;
                        r_state     <= ST_SEND_PAYLOAD;
                    end
                end
                ST_SEND_PAYLOAD: begin
                    if (w_outXfer) begin
                        r_dout      <= '0;
                        r_doutValid <= 1'b0;
                        r_doutStop  <= 1'b0;
                        r_state     <= ST_GET_HEADER;
                        r_dinAccept <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_dinAccept <= 1'b0;
                end
            endcase
        end
    end

    assign vai.DinAccept = r_dinAccept;
    assign vai.Dout      = r_dout;
    assign vai.DoutValid = r_doutValid;
    assign vai.DoutStart = r_doutStart;
    assign vai.DoutStop  = r_doutStop;

endmodule
`default_nettype wire

// File: tb/tb_vai_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_vai_regfile
// Description : Scoreboard bench for vai_regfile with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vai_regfile;

    localparam int             DW = 16;
    localparam int             AW = 4;
    localparam int             NR = 12;
    localparam logic [NR-1:0]  RO = 12'h001;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vai_regfile_if #(.DATA_W(DW)) vif ();
    logic [NR*DW-1:0] regs;

    vai_regfile #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .RO_MASK  (RO)
    ) dut (
        .Clk_i   (clk),
        .Reset_i (rst),
        .vai     (vif),
        .Regs_o  (regs)
    );

    beat_t         expq [$];
    logic [DW-1:0] model [NR];
    logic [DW-1:0] frm [$];
    int            total = 0;
    int            bad = 0;
    int            cycleCnt = 0;
    int            acceptCycle = 0;
    bit            randAccept = 0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [NR*DW-1:0] modelBus();
        logic [NR*DW-1:0] b;
        for (int i = 0; i < NR; i++) b[i*DW +: DW] = model[i];
        return b;
    endfunction

    always @(posedge clk) begin
        #1;
        if (randAccept) vif.DoutAccept = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops expected beats on every transfer and checks hold rules.
    logic          pv = 1'b0, pa, ps, pe;
    logic [DW-1:0] pd;
    beat_t         monBeat;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pa)
                check("out_stable", {vif.DoutValid, vif.DoutStart, vif.DoutStop, vif.Dout}, {1'b1, ps, pe, pd});
            if (vif.DoutValid)
                check("start_stop_excl", vif.DoutStart & vif.DoutStop, 0);
            if (vif.DoutValid && vif.DoutAccept) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", vif.Dout);
                end else begin
                    monBeat = expq.pop_front();
                    check("resp_beat", {vif.Dout, vif.DoutStart, vif.DoutStop}, monBeat);
                end
            end
            pv = vif.DoutValid;
            pa = vif.DoutAccept;
            ps = vif.DoutStart;
            pe = vif.DoutStop;
            pd = vif.Dout;
        end
    end

    // Called and returns at posedge+1.
    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
        int t = 0;
        vif.Din      = d;
        vif.DinValid = 1'b1;
        vif.DinStart = s;
        vif.DinStop  = e;
        while (!vif.DinAccept && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) timeout("din_accept");
        acceptCycle = cycleCnt;
        @(posedge clk); #1;
        vif.DinValid = 1'b0;
        vif.DinStart = 1'b0;
        vif.DinStop  = 1'b0;
    endtask

    // Frame-level model: decide the outcome of the whole frame, then queue it.
    task automatic issue_frame();
        logic [DW-1:0] h, pl;
        int  a;
        bit  rd, wr, err;
        h   = frm[0];
        a   = int'(h[7:4]);
        rd  = (h[3:0] == 4'd0) && (frm.size() == 1);
        wr  = (h[3:0] == 4'd1) && (frm.size() >= 2);
        err = !(rd || wr) || (a >= NR);
        if (!err && wr && RO[a]) err = 1;
        pl = '0;
        if (!err) begin
            if (wr) begin
                model[a] = frm[1];
                pl = frm[1];
            end else begin
                pl = model[a];
            end
        end
        expq.push_back('{d: {err, h[DW-2:0]}, s: 1'b1, e: 1'b0});
        expq.push_back('{d: pl, s: 1'b0, e: 1'b1});
        for (int i = 0; i < frm.size(); i++)
            send_beat(frm[i], i == 0, i == frm.size() - 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((expq.size() != 0 || !vif.DinAccept) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) timeout("idle");
    endtask

    task automatic wait_dout_valid();
        int t = 0;
        while (!vif.DoutValid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) timeout("dout_valid");
    endtask

    initial begin
        vif.Din        = '0;
        vif.DinValid   = 1'b0;
        vif.DinStart   = 1'b0;
        vif.DinStop    = 1'b0;
        vif.DoutAccept = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        #1;
        check("rst_dout", {vif.DoutValid, vif.DoutStart, vif.DoutStop, vif.Dout}, 0);
        check("rst_din_accept", vif.DinAccept, 0);
        check("rst_regs", regs, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_accept", vif.DinAccept, 0);
        @(posedge clk); #1;
        check("get_header_accept", vif.DinAccept, 1);

        randAccept = 1;
        frm = '{16'h0031, 16'hBEEF};
        issue_frame();
        wait_idle();
        check("reg3_written", regs[3*DW +: DW], 16'hBEEF);

        frm = '{16'h0030};
        issue_frame();
        wait_dout_valid();
        check("read_latency", cycleCnt - acceptCycle, 2);
        wait_idle();

        frm = '{16'h00D0};
        issue_frame();
        frm = '{16'h0001, 16'h1234};
        issue_frame();
        frm = '{16'h0007, 16'hAAAA, 16'h5A5A};
        issue_frame();
        wait_idle();
        check("reg0_read_only", regs[0 +: DW], 0);
        check("regs_model", regs, modelBus());

        send_beat(16'h5555, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("dropped_no_resp", vif.DoutValid, 0);
        check("dropped_still_accept", vif.DinAccept, 1);

        // Backpressure on both response beats.
        randAccept = 0;
        vif.DoutAccept = 1'b0;
        frm = '{16'h0030};
        issue_frame();
        wait_dout_valid();
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_hdr", {vif.DoutValid, vif.DoutStart, vif.DoutStop, vif.Dout}, {3'b110, 16'h0030});
            check("hold_hdr_din_accept", vif.DinAccept, 0);
        end
        vif.DoutAccept = 1'b1;
        @(posedge clk); #1;
        vif.DoutAccept = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_pl", {vif.DoutValid, vif.DoutStart, vif.DoutStop, vif.Dout}, {3'b101, model[3]});
            check("hold_pl_din_accept", vif.DinAccept, 0);
        end
        vif.DoutAccept = 1'b1;
        @(posedge clk); #1;
        randAccept = 1;
        wait_idle();

        for (int n = 0; n < 60; n++) begin
            int            kind;
            logic [DW-1:0] h;
            kind = $urandom_range(0, 4);
            h    = DW'($urandom);
            frm.delete();
            case (kind)
                0: begin
                    h[3:0] = 4'd0;
                    h[7:4] = 4'($urandom_range(0, NR - 1));
                    frm.push_back(h);
                end
                1: begin
                    h[3:0] = 4'd0;
                    frm.push_back(h);
                end
                2: begin
                    h[3:0] = 4'd1;
                    frm.push_back(h);
                    frm.push_back(DW'($urandom));
                    if ($urandom_range(0, 3) == 0) frm.push_back(DW'($urandom));
                end
                3: begin
                    h[3:0] = 4'($urandom_range(2, 15));
                    frm.push_back(h);
                    repeat ($urandom_range(0, 2)) frm.push_back(DW'($urandom));
                end
                default: begin
                    h[3:0] = 4'($urandom_range(0, 1));
                    frm.push_back(h);
                    if (h[3:0] == 4'd0) frm.push_back(DW'($urandom));
                end
            endcase
            issue_frame();
        end
        wait_idle();
        check("regs_after_random", regs, modelBus());

        // Reset while the payload beat is pending.
        randAccept = 0;
        vif.DoutAccept = 1'b0;
        frm = '{16'h0030};
        issue_frame();
        wait_dout_valid();
        vif.DoutAccept = 1'b1;
        @(posedge clk); #1;
        vif.DoutAccept = 1'b0;
        check("in_send_payload", {vif.DoutValid, vif.DoutStop}, 2'b11);
        rst = 1'b1;
        #1;
        check("reset_dout_valid", vif.DoutValid, 0);
        check("reset_regs", regs, 0);
        check("reset_din_accept", vif.DinAccept, 0);
        expq.delete();
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_reset_idle", vif.DinAccept, 0);
        @(posedge clk); #1;
        check("post_reset_get_header", vif.DinAccept, 1);
        randAccept = 1;
        frm = '{16'h0030};
        issue_frame();
        wait_idle();
        check("regs_after_reset", regs, modelBus());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
